// File: rtl/ov5642_dvp_capture.sv
// OV5642 DVP capture: registers the sensor bus, frames bytes between vsync pulses and
// emits them as an AXIS byte stream with tlast on the final byte, plus frame statistics.
module ov5642_dvp_capture #(
   parameter logic VSYNC_ACTIVE_HIGH = 1'b1,
   parameter logic HREF_ACTIVE_HIGH  = 1'b1
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  d,
   input  logic        capture_en,
   input  logic        err_clr,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   output logic        m_tlast,
   output logic [15:0] frame_count,
   output logic [11:0] line_count,
   output logic [12:0] line_bytes,
   output logic        err_len,
   output logic        err_empty,
   output logic [1:0]  state_dbg
);

   // Stream handshake: m_tvalid is high for exactly one cycle per captured byte and there
   // is no tready; the consumer must accept every beat in the cycle it is presented.

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      IDLE   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam logic [12:0] BYTE_MAX = 13'h1FFF;
   localparam logic [11:0] LINE_MAX = 12'hFFF;

   state_t      state;
   state_t      state_nx;

   logic        vs_norm;
   logic        hr_norm;
   logic        vs_s1;
   logic        vs_s2;
   logic        hr_s1;
   logic        hr_s2;
   logic [7:0]  d_s1;

   logic        vs_edge;
   logic        hr_rise;
   logic        hr_fall;
   logic        byte_ok;

   logic        capture;
   logic        flush;
   logic        empty_end;
   logic        line_end;
   logic        line_start;
   logic        len_set;
   logic        empty_set;

   logic [7:0]  hold_data;
   logic        hold_full;
   logic [12:0] byte_cnt;
   logic [12:0] ref_len;
   logic [11:0] line_cnt;

   assign vs_norm = VSYNC_ACTIVE_HIGH ? vsync : ~vsync;
   assign hr_norm = HREF_ACTIVE_HIGH  ? href  : ~href;

   // Everything downstream sees only the registered, polarity-normalised bus.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_s1 <= 1'b0;
         vs_s2 <= 1'b0;
         hr_s1 <= 1'b0;
         hr_s2 <= 1'b0;
         d_s1  <= 8'd0;
      end else begin
         vs_s1 <= vs_norm;
         vs_s2 <= vs_s1;
         hr_s1 <= hr_norm;
         hr_s2 <= hr_s1;
         d_s1  <= d;
      end
   end

   assign vs_edge = vs_s1 & ~vs_s2;
   assign hr_rise = hr_s1 & ~hr_s2;
   assign hr_fall = ~hr_s1 & hr_s2;
   assign byte_ok = hr_s1 & ~vs_s1;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SYNC;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      capture   = 1'b0;
      flush     = 1'b0;
      empty_end = 1'b0;
      line_end  = 1'b0;
      case (state)
         SYNC: begin
            if (vs_edge && capture_en) begin
               state_nx = IDLE;
            end
         end
         IDLE: begin
            if (vs_edge) begin
               empty_end = 1'b1;
               if (!capture_en) begin
                  state_nx = SYNC;
               end
            end else if (byte_ok) begin
               capture  = 1'b1;
               state_nx = ACTIVE;
            end
         end
         ACTIVE: begin
            if (vs_edge) begin
               flush    = 1'b1;
               state_nx = capture_en ? IDLE : SYNC;
            end else begin
               capture  = byte_ok;
               line_end = hr_fall;
            end
         end
         default: begin
            state_nx = SYNC;
         end
      endcase
   end

   // The first byte of a frame may arrive mid-href, so it also starts a fresh line count.
   assign line_start = hr_rise | (state == IDLE);
   assign len_set    = line_end && (line_cnt != 12'd0) && (byte_cnt != ref_len);
   assign empty_set  = empty_end | (flush & ~hold_full);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         m_tdata     <= 8'd0;
         m_tvalid    <= 1'b0;
         m_tlast     <= 1'b0;
         hold_data   <= 8'd0;
         hold_full   <= 1'b0;
         byte_cnt    <= 13'd0;
         ref_len     <= 13'd0;
         line_cnt    <= 12'd0;
         frame_count <= 16'd0;
         line_count  <= 12'd0;
         line_bytes  <= 13'd0;
         err_len     <= 1'b0;
         err_empty   <= 1'b0;
      end else begin
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;

         if (capture) begin
            if (hold_full) begin
               m_tdata  <= hold_data;
               m_tvalid <= 1'b1;
            end
            hold_data <= d_s1;
            hold_full <= 1'b1;
            if (line_start) begin
               byte_cnt <= 13'd1;
            end else if (byte_cnt != BYTE_MAX) begin
               byte_cnt <= byte_cnt + 13'd1;
            end
         end

         if (line_end) begin
            line_bytes <= byte_cnt;
            if (line_cnt == 12'd0) begin
               ref_len <= byte_cnt;
            end
            if (line_cnt != LINE_MAX) begin
               line_cnt <= line_cnt + 12'd1;
            end
         end

         // The held byte is the true last byte of the frame once vsync arrives.
         if (flush && hold_full) begin
            m_tdata     <= hold_data;
            m_tvalid    <= 1'b1;
            m_tlast     <= 1'b1;
            hold_full   <= 1'b0;
            frame_count <= frame_count + 16'd1;
            line_count  <= line_cnt;
         end

         if (vs_edge) begin
            line_cnt <= 12'd0;
         end

         err_len   <= len_set   | (err_len   & ~err_clr);
         err_empty <= empty_set | (err_empty & ~err_clr);
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_ov5642_dvp_capture.sv
// Bench for ov5642_dvp_capture: drives one logical sensor stream into a normal-polarity and an
// inverted-polarity instance and checks both against a frame-level model and literal values.
module tb_ov5642_dvp_capture;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n      = 1'b1;
   logic       vs         = 1'b0;
   logic       hr         = 1'b0;
   logic [7:0] d          = 8'd0;
   logic       capture_en = 1'b0;
   logic       err_clr    = 1'b0;
   logic       vsync_inv;
   logic       href_inv;

   assign vsync_inv = ~vs;
   assign href_inv  = ~hr;

   logic [7:0]  a_tdata, b_tdata;
   logic        a_tvalid, b_tvalid, a_tlast, b_tlast;
   logic [15:0] a_fc, b_fc;
   logic [11:0] a_lc, b_lc;
   logic [12:0] a_lb, b_lb;
   logic        a_elen, b_elen, a_eemp, b_eemp;
   logic [1:0]  a_st, b_st;

   ov5642_dvp_capture dut (
      .pclk(clk), .rst_n(rst_n), .vsync(vs), .href(hr), .d(d),
      .capture_en(capture_en), .err_clr(err_clr),
      .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tlast(a_tlast),
      .frame_count(a_fc), .line_count(a_lc), .line_bytes(a_lb),
      .err_len(a_elen), .err_empty(a_eemp), .state_dbg(a_st)
   );

   ov5642_dvp_capture #(.VSYNC_ACTIVE_HIGH(1'b0), .HREF_ACTIVE_HIGH(1'b0)) dut_inv (
      .pclk(clk), .rst_n(rst_n), .vsync(vsync_inv), .href(href_inv), .d(d),
      .capture_en(capture_en), .err_clr(err_clr),
      .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tlast(b_tlast),
      .frame_count(b_fc), .line_count(b_lc), .line_bytes(b_lb),
      .err_len(b_elen), .err_empty(b_eemp), .state_dbg(b_st)
   );

   // scoreboard and frame-level model
   logic [8:0] exp_q[$];
   logic [8:0] exp_q_inv[$];
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] last_a = 8'd0;
   logic [7:0] last_b = 8'd0;

   bit          armed = 1'b0;
   int          cur_lines = 0;
   int          cur_ref = 0;
   int          cur_bytes = 0;
   logic [15:0] exp_frame_count = 16'd0;
   int          exp_line_count = 0;
   int          exp_line_bytes = 0;
   logic        exp_err_len = 1'b0;
   logic        exp_err_empty = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endfunction

   function automatic logic [7:0] check_beat(input string who, input logic tv, input logic tl,
                                             input logic [7:0] td, input logic have,
                                             input logic [8:0] e, input logic [7:0] last);
      logic [7:0] nl;
      nl = last;
      if (tv) begin
         if (!have) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s unexpected beat: got data=%02h last=%0b, required no beat", who, td, tl);
         end else begin
            check({who, " beat data"}, 32'(td), 32'(e[7:0]));
            check({who, " beat last"}, 32'(tl), 32'(e[8]));
            nl = e[7:0];
         end
      end else begin
         check({who, " tlast while idle"}, 32'(tl), 32'd0);
         check({who, " tdata hold"}, 32'(td), 32'(last));
      end
      return nl;
   endfunction

   always @(negedge clk) begin
      logic [8:0] e;
      logic       have;
      if (!rst_n) begin
         last_a = 8'd0;
         last_b = 8'd0;
      end else begin
         have = 1'b0;
         e    = '0;
         if (a_tvalid && exp_q.size() > 0) begin
            have = 1'b1;
            e    = exp_q.pop_front();
         end
         last_a = check_beat("dut", a_tvalid, a_tlast, a_tdata, have, e, last_a);
         have = 1'b0;
         e    = '0;
         if (b_tvalid && exp_q_inv.size() > 0) begin
            have = 1'b1;
            e    = exp_q_inv.pop_front();
         end
         last_b = check_beat("dut_inv", b_tvalid, b_tlast, b_tdata, have, e, last_b);
      end
   end

   task automatic model_reset();
      exp_q.delete();
      exp_q_inv.delete();
      armed           = 1'b0;
      cur_lines       = 0;
      cur_ref         = 0;
      cur_bytes       = 0;
      exp_frame_count = 16'd0;
      exp_line_count  = 0;
      exp_line_bytes  = 0;
      exp_err_len     = 1'b0;
      exp_err_empty   = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " tdata"},  32'(a_tdata), 0);  check({tag, " inv tdata"},  32'(b_tdata), 0);
      check({tag, " tvalid"}, 32'(a_tvalid), 0); check({tag, " inv tvalid"}, 32'(b_tvalid), 0);
      check({tag, " tlast"},  32'(a_tlast), 0);  check({tag, " inv tlast"},  32'(b_tlast), 0);
      check({tag, " frame_count"}, 32'(a_fc), 0); check({tag, " inv frame_count"}, 32'(b_fc), 0);
      check({tag, " line_count"},  32'(a_lc), 0); check({tag, " line_bytes"}, 32'(a_lb), 0);
      check({tag, " err_len"},     32'(a_elen), 0); check({tag, " err_empty"}, 32'(a_eemp), 0);
      check({tag, " state SYNC"},  32'(a_st), 0); check({tag, " inv state SYNC"}, 32'(b_st), 0);
   endtask

   task automatic check_status(input string tag);
      check({tag, " frame_count"},     32'(a_fc),   32'(exp_frame_count));
      check({tag, " inv frame_count"}, 32'(b_fc),   32'(exp_frame_count));
      check({tag, " line_count"},      32'(a_lc),   32'(exp_line_count));
      check({tag, " inv line_count"},  32'(b_lc),   32'(exp_line_count));
      check({tag, " line_bytes"},      32'(a_lb),   32'(exp_line_bytes));
      check({tag, " inv line_bytes"},  32'(b_lb),   32'(exp_line_bytes));
      check({tag, " err_len"},         32'(a_elen), 32'(exp_err_len));
      check({tag, " inv err_len"},     32'(b_elen), 32'(exp_err_len));
      check({tag, " err_empty"},       32'(a_eemp), 32'(exp_err_empty));
      check({tag, " inv err_empty"},   32'(b_eemp), 32'(exp_err_empty));
   endtask

   // driver tasks
   task automatic drive_line(input int len, input logic [7:0] start);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         hr = 1'b1;
         d  = start + 8'(i);
         if (armed) begin
            exp_q.push_back({1'b0, d});
            exp_q_inv.push_back({1'b0, d});
         end
      end
      @(negedge clk);
      hr = 1'b0;
      d  = 8'($urandom_range(0, 255));
      if (armed) begin
         cur_bytes += len;
         exp_line_bytes = len;
         if (cur_lines == 0) cur_ref = len;
         else if (len != cur_ref) exp_err_len = 1'b1;
         cur_lines++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic vsync_pulse();
      logic [8:0] e;
      @(negedge clk);
      vs = 1'b1;
      hr = 1'b0;
      if (armed) begin
         if (cur_bytes > 0) begin
            e = exp_q.pop_back();     e[8] = 1'b1; exp_q.push_back(e);
            e = exp_q_inv.pop_back(); e[8] = 1'b1; exp_q_inv.push_back(e);
            exp_frame_count = exp_frame_count + 16'd1;
            exp_line_count  = cur_lines;
         end else begin
            exp_err_empty = 1'b1;
         end
      end
      armed     = capture_en;
      cur_lines = 0;
      cur_bytes = 0;
      cur_ref   = 0;
      @(negedge clk);
      hr = 1'b1;               // href during vsync must be ignored
      d  = 8'hEE;
      @(negedge clk);
      hr = 1'b0;
      @(negedge clk);
      vs = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic err_clr_pulse();
      @(negedge clk);
      err_clr       = 1'b1;
      exp_err_len   = 1'b0;
      exp_err_empty = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic full_frame(input int nlines, input int len, input logic [7:0] start);
      for (int l = 0; l < nlines; l++) drive_line(len, start + 8'(l * len));
      vsync_pulse();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      model_reset();
      rst_n      = 1'b1;
      capture_en = 1'b1;
      repeat (2) @(negedge clk);

      // bytes before the first vsync are discarded
      drive_line(4, 8'hA0);
      drive_line(3, 8'hB0);
      vsync_pulse();
      check_status("armed");

      // 4 lines x 6 bytes, 0x00..0x17
      full_frame(4, 6, 8'h00);
      check("frame1 frame_count", 32'(a_fc), 1);
      check("frame1 line_count", 32'(a_lc), 4);
      check("frame1 line_bytes", 32'(a_lb), 6);
      check("frame1 inv frame_count", 32'(b_fc), 1);
      check("frame1 drained", 32'(exp_q.size()), 0);
      check_status("frame1");

      // line lengths 6,6,5,6
      drive_line(6, 8'h30);
      drive_line(6, 8'h36);
      drive_line(5, 8'h3C);
      check("err_len after short line", 32'(a_elen), 1);
      check("inv err_len after short line", 32'(b_elen), 1);
      drive_line(6, 8'h41);
      vsync_pulse();
      check("frame2 frame_count", 32'(a_fc), 2);
      check("frame2 line_bytes", 32'(a_lb), 6);
      check_status("frame2");
      err_clr_pulse();
      check("err_len cleared", 32'(a_elen), 0);
      check_status("after clr");
      full_frame(3, 4, 8'h50);
      check("clean frame err_len", 32'(a_elen), 0);
      check("frame3 line_count", 32'(a_lc), 3);
      check("frame3 line_bytes", 32'(a_lb), 4);
      check_status("frame3");

      // zero-byte frame
      vsync_pulse();
      check("empty frame err_empty", 32'(a_eemp), 1);
      check("empty frame frame_count", 32'(a_fc), 3);
      check_status("empty frame");
      err_clr_pulse();
      check_status("after empty clr");

      // capture disabled for one frame, then re-enabled
      capture_en = 1'b0;
      vsync_pulse();
      drive_line(5, 8'h60);
      drive_line(5, 8'h65);
      capture_en = 1'b1;
      vsync_pulse();
      full_frame(2, 3, 8'h70);
      check("reenabled frame_count", 32'(a_fc), 4);
      check_status("reenabled");
      err_clr_pulse();

      // reset after 10 bytes of a frame
      drive_line(6, 8'h80);
      drive_line(4, 8'h86);
      check("held byte at reset", 32'(exp_q.size()), 1);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      exp_q_inv.delete();
      repeat (2) @(negedge clk);
      check_zero("mid reset");
      model_reset();
      rst_n = 1'b1;
      drive_line(6, 8'h90);
      vsync_pulse();
      full_frame(4, 6, 8'hA0);
      check("post reset frame_count", 32'(a_fc), 1);
      check("post reset line_count", 32'(a_lc), 4);
      check("post reset line_bytes", 32'(a_lb), 6);
      check_status("post reset");

      repeat (5) @(negedge clk);
      check("final drained", 32'(exp_q.size()), 0);
      check("final inv drained", 32'(exp_q_inv.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ov5642_dvp_capture.md
OV5642_DVP_CAPTURE -- requirements
Module: ov5642_dvp_capture

Interface
REQ-001 The block SHALL have parameter VSYNC_ACTIVE_HIGH, default 1: 1 = vsync pulse high, 0 = vsync pulse low.
REQ-002 The block SHALL have parameter HREF_ACTIVE_HIGH, default 1: 1 = href high while data valid, 0 = href low while data valid.
REQ-003 pclk  in  1  sensor pixel clock; sole clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 vsync  in  1  sensor frame sync.
REQ-006 href  in  1  sensor line-valid qualifier.
REQ-007 d  in  8  sensor data byte.
REQ-008 capture_en  in  1  capture enable, honoured only at frame boundaries.
REQ-009 err_clr  in  1  single-cycle clear of sticky error flags.
REQ-010 m_tdata  out  8  AXIS byte to ov5642_byte_aligner.
REQ-011 m_tvalid  out  1  AXIS valid; no tready, no backpressure.
REQ-012 m_tlast  out  1  AXIS last; marks final byte of a frame.
REQ-013 frame_count  out  16  completed frames, wraps 0xFFFF->0.
REQ-014 line_count  out  12  lines in last completed frame.
REQ-015 line_bytes  out  13  byte count of last completed line.
REQ-016 err_len  out  1  sticky: a line length differed from first line of same frame.
REQ-017 err_empty  out  1  sticky: frame ended with zero bytes captured.

Function
REQ-018 vsync, href, d SHALL be registered once into input stage s1 before any use; vsync edge SHALL be detected from s1 and a second register s2.
REQ-019 Polarity SHALL be normalised per parameters; "vsync active" and "href active" below mean after normalisation.
REQ-020 FSM states: SYNC, IDLE, ACTIVE.
REQ-021 SYNC: entered from reset; discards all bytes; on vsync active-edge -> IDLE if capture_en=1, else stay.
REQ-022 IDLE: on first href-active byte while vsync inactive -> ACTIVE; on vsync active-edge with capture_en=0 -> SYNC.
REQ-023 ACTIVE: captures bytes with href active and vsync inactive; on vsync active-edge -> flush, then IDLE (capture_en=1) or SYNC (capture_en=0).
REQ-024 One-byte hold register SHALL delay output so tlast can mark the true last byte.
REQ-025 Captured byte with hold full: hold contents SHALL be output next cycle with m_tvalid=1, m_tlast=0; new byte enters hold.
REQ-026 Captured byte with hold empty: byte enters hold, no output.
REQ-027 Flush on vsync active-edge with hold full: hold SHALL be output with m_tvalid=1, m_tlast=1 for exactly one cycle; hold emptied.
REQ-028 Flush with hold empty (zero-byte frame): no output, err_empty set, frame_count not incremented.
REQ-029 Outputs m_tdata/m_tvalid/m_tlast SHALL be registered; m_tvalid high exactly once per captured byte.
REQ-030 m_tdata SHALL hold its last value when m_tvalid=0.
REQ-031 Line counter SHALL increment on href active->inactive edge in ACTIVE; byte counter SHALL reset at each href active-edge.
REQ-032 At each line end line_bytes SHALL update; first line of frame latches reference length; mismatch on later lines sets err_len.
REQ-033 At flush with bytes > 0: line_count updated, frame_count incremented, same cycle as m_tlast.
REQ-034 Byte counter SHALL saturate at 8191; line counter SHALL saturate at 4095.
REQ-035 href active while vsync active SHALL be ignored.
REQ-036 err_clr SHALL clear both sticky flags; a same-cycle set event SHALL win over clear.

Reset
REQ-037 On rst_n low: FSM=SYNC, hold empty, m_tdata=0, m_tvalid=0, m_tlast=0, all counters 0, err flags 0, s1/s2 normalised inactive.
REQ-038 Reset asserted mid-frame SHALL abort without emitting m_tlast; after release capture resumes only after next vsync active-edge.

Verification
REQ-039 Reset release, capture_en=1, 4 lines x 6 bytes 0x00..0x17 then vsync -> 24 m_tvalid pulses in order, m_tlast only with 0x17, frame_count=1, line_count=4, line_bytes=6.
REQ-040 Bytes driven before first vsync edge -> no m_tvalid until after vsync; first frame output complete and correct.
REQ-041 Line lengths 6,6,5,6 -> err_len=1 after line 3; err_clr pulse -> 0; next clean frame keeps 0.
REQ-042 vsync, vsync with no href -> err_empty=1, no m_tlast, frame_count unchanged.
REQ-043 rst_n pulsed after 10 bytes of frame -> all outputs 0, no m_tlast; next full frame after vsync captured correctly.
REQ-044 VSYNC_ACTIVE_HIGH=0, HREF_ACTIVE_HIGH=0 with inverted stimulus of REQ-039 -> identical m_tdata/m_tlast sequence.
